rtp_top: RTL and testbench

//  Self-starting ray/triangle intersection engine (ray-tracing processor top).

---
 rtl/rtp_top.sv | 233 +++++++++++++++++++++++
 tb/tb_rtp_top.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rtp_top.sv
// rtp_top: self-starting ray/triangle intersection engine.
// Every ray in the ray memory is tested against every triangle (Woop
// unit-triangle form). The closest positive hit per ray is published on the
// outputs when that ray completes. Divisions are counted for profiling.

// RomMem: read-only table loaded from outside the design, asynchronous read.
module RomMem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);
  logic [DATA_W-1:0] mem [DEPTH];

  assign data_o = mem[addr_i];
endmodule

module rtp_top #(
  parameter int NUM_RAYS = 16,
  parameter int NUM_TRIS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic [DATA_W-1:0] io_hitT,
  output logic [31:0]       io_ray_id_triangle,
  output logic              io_rtp_finish,
  output logic [63:0]       io_counter_fdiv
);
  localparam int TRI_ROWS  = 3 * NUM_TRIS;
  localparam int RAY_AW    = (NUM_RAYS > 1) ? $clog2(NUM_RAYS) : 1;
  localparam int TRI_IW    = (NUM_TRIS > 1) ? $clog2(NUM_TRIS) : 1;
  localparam int TRI_AW    = $clog2(TRI_ROWS);
  localparam int DIVN_W    = DATA_W + 16;
  localparam int DIV_STEPS = DIVN_W / 2;
  localparam logic [DATA_W-1:0] ONE    = DATA_W'(32'h0001_0000);
  localparam logic [15:0]       NO_HIT = 16'hFFFF;

  typedef enum logic [2:0] {
    LOAD_RAY, TRI_ROW0, DIV, TRI_ROW1, TRI_ROW2, UPDATE, RAY_DONE, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [RAY_AW-1:0]   rayIdx_q, rayIdx_d;
  logic [TRI_IW-1:0]   triIdx_q, triIdx_d;
  logic [DATA_W-1:0]   ox_q, ox_d, oy_q, oy_d, oz_q, oz_d;
  logic [DATA_W-1:0]   dx_q, dx_d, dy_q, dy_d, dz_q, dz_d;
  logic [DATA_W-1:0]   bestT_q, bestT_d, t_q, t_d, u_q, u_d;
  logic [15:0]         bestId_q, bestId_d;
  logic                hit_q, hit_d;
  logic [DATA_W:0]     divRem_q, divRem_d;
  logic [DIVN_W-1:0]   divQuo_q, divQuo_d;
  logic [DATA_W-1:0]   divDen_q, divDen_d;
  logic                divNeg_q, divNeg_d;
  logic [4:0]          divCnt_q, divCnt_d;
  logic [DATA_W-1:0]   hitTOut_q, hitTOut_d;
  logic [31:0]         rayIdTri_q, rayIdTri_d;
  logic                finish_q, finish_d;
  logic [63:0]         fdiv_q, fdiv_d;

  logic [DATA_W-1:0] rayOx, rayOy, rayOz, rayDx, rayDy, rayDz, rayTmax;
  logic [DATA_W-1:0] triX, triY, triZ, triW;
  logic [1:0]        rowSel;
  logic [TRI_AW-1:0] triAddr;

  // Q16.16 multiply: full signed product, keep the middle word.
  function automatic logic [DATA_W-1:0] fxMul(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] p;
    p = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
    return p[DATA_W+15:16];
  endfunction

  RomMem #(.DATA_W(DATA_W), .DEPTH(NUM_RAYS)) ray_origx (.addr_i(rayIdx_q), .data_o(rayOx));
  RomMem #(.DATA_W(DATA_W), .DEPTH(NUM_RAYS)) ray_origy (.addr_i(rayIdx_q), .data_o(rayOy));
  RomMem #(.DATA_W(DATA_W), .DEPTH(NUM_RAYS)) ray_origz (.addr_i(rayIdx_q), .data_o(rayOz));
  RomMem #(.DATA_W(DATA_W), .DEPTH(NUM_RAYS)) ray_dirx  (.addr_i(rayIdx_q), .data_o(rayDx));
  RomMem #(.DATA_W(DATA_W), .DEPTH(NUM_RAYS)) ray_diry  (.addr_i(rayIdx_q), .data_o(rayDy));
  RomMem #(.DATA_W(DATA_W), .DEPTH(NUM_RAYS)) ray_dirz  (.addr_i(rayIdx_q), .data_o(rayDz));
  RomMem #(.DATA_W(DATA_W), .DEPTH(NUM_RAYS)) ray_hitT  (.addr_i(rayIdx_q), .data_o(rayTmax));
  RomMem #(.DATA_W(DATA_W), .DEPTH(TRI_ROWS)) tri_x     (.addr_i(triAddr),  .data_o(triX));
  RomMem #(.DATA_W(DATA_W), .DEPTH(TRI_ROWS)) tri_y     (.addr_i(triAddr),  .data_o(triY));
  RomMem #(.DATA_W(DATA_W), .DEPTH(TRI_ROWS)) tri_z     (.addr_i(triAddr),  .data_o(triZ));
  RomMem #(.DATA_W(DATA_W), .DEPTH(TRI_ROWS)) tri_w     (.addr_i(triAddr),  .data_o(triW));

  assign io_hitT            = hitTOut_q;
  assign io_ray_id_triangle = rayIdTri_q;
  assign io_rtp_finish      = finish_q;
  assign io_counter_fdiv    = fdiv_q;

  // State and datapath registers; reset aborts any sweep and restarts at ray 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= LOAD_RAY;  rayIdx_q <= '0;  triIdx_q <= '0;
      ox_q <= '0;  oy_q <= '0;  oz_q <= '0;
      dx_q <= '0;  dy_q <= '0;  dz_q <= '0;
      bestT_q <= '0;  bestId_q <= '0;  t_q <= '0;  u_q <= '0;  hit_q <= 1'b0;
      divRem_q <= '0;  divQuo_q <= '0;  divDen_q <= '0;  divNeg_q <= 1'b0;
      divCnt_q <= '0;
      hitTOut_q <= '0;  rayIdTri_q <= '0;  finish_q <= 1'b0;  fdiv_q <= '0;
    end else begin
      state_q <= state_d;  rayIdx_q <= rayIdx_d;  triIdx_q <= triIdx_d;
      ox_q <= ox_d;  oy_q <= oy_d;  oz_q <= oz_d;
      dx_q <= dx_d;  dy_q <= dy_d;  dz_q <= dz_d;
      bestT_q <= bestT_d;  bestId_q <= bestId_d;  t_q <= t_d;  u_q <= u_d;
      hit_q <= hit_d;
      divRem_q <= divRem_d;  divQuo_q <= divQuo_d;  divDen_q <= divDen_d;
      divNeg_q <= divNeg_d;  divCnt_q <= divCnt_d;
      hitTOut_q <= hitTOut_d;  rayIdTri_q <= rayIdTri_d;
      finish_q <= finish_d;  fdiv_q <= fdiv_d;
    end
  end

  // Sweep sequencing, shared dot-product datapath and two-bit-per-cycle divider.
  always_comb begin
    logic [DATA_W-1:0] dotO, dotD, ozVal, dzVal, baryVal, ozAbs, dzAbs;
    logic [DATA_W-1:0] tDiv, sumUV;
    logic [DATA_W:0]   remW;
    logic [DIVN_W-1:0] quoW;

    state_d = state_q;  rayIdx_d = rayIdx_q;  triIdx_d = triIdx_q;
    ox_d = ox_q;  oy_d = oy_q;  oz_d = oz_q;
    dx_d = dx_q;  dy_d = dy_q;  dz_d = dz_q;
    bestT_d = bestT_q;  bestId_d = bestId_q;  t_d = t_q;  u_d = u_q;
    hit_d = hit_q;
    divRem_d = divRem_q;  divQuo_d = divQuo_q;  divDen_d = divDen_q;
    divNeg_d = divNeg_q;  divCnt_d = divCnt_q;
    hitTOut_d = hitTOut_q;  rayIdTri_d = rayIdTri_q;
    finish_d = finish_q;  fdiv_d = fdiv_q;

    case (state_q)
      TRI_ROW1: rowSel = 2'd1;
      TRI_ROW2: rowSel = 2'd2;
      default:  rowSel = 2'd0;
    endcase
    triAddr = TRI_AW'(32'(triIdx_q) * 32'd3 + 32'(rowSel));

    dotO    = fxMul(ox_q, triX) + fxMul(oy_q, triY) + fxMul(oz_q, triZ);
    dotD    = fxMul(dx_q, triX) + fxMul(dy_q, triY) + fxMul(dz_q, triZ);
    ozVal   = triW - dotO;
    dzVal   = dotD;
    baryVal = triW + dotO + fxMul(t_q, dotD);
    ozAbs   = ozVal[DATA_W-1] ? -ozVal : ozVal;
    dzAbs   = dzVal[DATA_W-1] ? -dzVal : dzVal;
    sumUV   = u_q + baryVal;

    remW = divRem_q;
    quoW = divQuo_q;
    for (int i = 0; i < 2; i++) begin
      remW = {remW[DATA_W-1:0], quoW[DIVN_W-1]};
      quoW = {quoW[DIVN_W-2:0], 1'b0};
      if (remW >= {1'b0, divDen_q}) begin
        remW    = remW - {1'b0, divDen_q};
        quoW[0] = 1'b1;
      end
    end
    tDiv = divNeg_q ? -quoW[DATA_W-1:0] : quoW[DATA_W-1:0];

    case (state_q)
      LOAD_RAY: begin
        ox_d = rayOx;  oy_d = rayOy;  oz_d = rayOz;
        dx_d = rayDx;  dy_d = rayDy;  dz_d = rayDz;
        bestT_d  = rayTmax;
        bestId_d = NO_HIT;
        triIdx_d = '0;
        state_d  = TRI_ROW0;
      end
      TRI_ROW0: begin
        hit_d = 1'b0;
        if (dzVal == '0) begin
          state_d = UPDATE;
        end else begin
          divRem_d = '0;
          divQuo_d = {ozAbs, 16'h0000};
          divDen_d = dzAbs;
          divNeg_d = ozVal[DATA_W-1] ^ dzVal[DATA_W-1];
          divCnt_d = 5'(DIV_STEPS - 1);
          fdiv_d   = fdiv_q + 64'd1;
          state_d  = DIV;
        end
      end
      DIV: begin
        divRem_d = remW;
        divQuo_d = quoW;
        if (divCnt_q == '0) begin
          t_d = tDiv;
          if ($signed(tDiv) <= 0 || $signed(tDiv) >= $signed(bestT_q))
            state_d = UPDATE;
          else
            state_d = TRI_ROW1;
        end else begin
          divCnt_d = divCnt_q - 5'd1;
        end
      end
      TRI_ROW1: begin
        u_d     = baryVal;
        state_d = baryVal[DATA_W-1] ? UPDATE : TRI_ROW2;
      end
      TRI_ROW2: begin
        hit_d   = !baryVal[DATA_W-1] && ($signed(sumUV) <= $signed(ONE));
        state_d = UPDATE;
      end
      UPDATE: begin
        if (hit_q) begin
          bestT_d  = t_q;
          bestId_d = 16'(triIdx_q);
        end
        if (triIdx_q == TRI_IW'(NUM_TRIS - 1)) begin
          state_d = RAY_DONE;
        end else begin
          triIdx_d = triIdx_q + TRI_IW'(1);
          state_d  = TRI_ROW0;
        end
      end
      RAY_DONE: begin
        hitTOut_d  = bestT_q;
        rayIdTri_d = {16'(rayIdx_q), bestId_q};
        if (rayIdx_q == RAY_AW'(NUM_RAYS - 1)) begin
          state_d = DONE;
        end else begin
          rayIdx_d = rayIdx_q + RAY_AW'(1);
          state_d  = LOAD_RAY;
        end
      end
      DONE: begin
        finish_d = 1'b1;
      end
      default: state_d = LOAD_RAY;
    endcase
  end
endmodule

// File: tb/tb_rtp_top.sv
// tb_rtp_top: directed scenarios for the ray/triangle sweep engine.
// Ray 0 is o=(0,0,-5), d=(0,0,1), tmax=100; triangles are built so that the
// hit distance t and barycentrics u, v are exactly the chosen values.
module tb_rtp_top;
  localparam int NUM_RAYS = 16;
  localparam int NUM_TRIS = 32;
  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] TMAX = 32'h0064_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] io_hitT;
  logic [31:0] io_ray_id_triangle;
  logic        io_rtp_finish;
  logic [63:0] io_counter_fdiv;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  rtp_top #(.NUM_RAYS(NUM_RAYS), .NUM_TRIS(NUM_TRIS), .DATA_W(32)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_hitT            (io_hitT),
    .io_ray_id_triangle (io_ray_id_triangle),
    .io_rtp_finish      (io_rtp_finish),
    .io_counter_fdiv    (io_counter_fdiv)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setRay(input int r, input logic [31:0] ox, input logic [31:0] oy,
                        input logic [31:0] oz, input logic [31:0] dx,
                        input logic [31:0] dy, input logic [31:0] dz,
                        input logic [31:0] tmax);
    dut.ray_origx.mem[r] = ox;  dut.ray_origy.mem[r] = oy;
    dut.ray_origz.mem[r] = oz;  dut.ray_dirx.mem[r]  = dx;
    dut.ray_diry.mem[r]  = dy;  dut.ray_dirz.mem[r]  = dz;
    dut.ray_hitT.mem[r]  = tmax;
  endtask

  task automatic setTriRow(input int row, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] z, input logic [31:0] w);
    dut.tri_x.mem[row] = x;  dut.tri_y.mem[row] = y;
    dut.tri_z.mem[row] = z;  dut.tri_w.mem[row] = w;
  endtask

  // Triangle k hit by the standard ray at integer t with barycentrics u, v.
  task automatic setTri(input int k, input int tInt, input logic [31:0] u,
                        input logic [31:0] v);
    logic [31:0] w0, w1;
    w0 = 32'((tInt - 5) * 65536);
    w1 = 32'((5 - tInt) * 65536) + u;
    setTriRow(3 * k,     32'h0, 32'h0, ONE,   w0);
    setTriRow(3 * k + 1, 32'h0, 32'h0, ONE,   w1);
    setTriRow(3 * k + 2, 32'h0, 32'h0, 32'h0, v);
  endtask

  task automatic setStdRay(input int r);
    setRay(r, 32'h0, 32'h0, 32'hFFFB_0000, 32'h0, 32'h0, ONE, TMAX);
  endtask

  // Holds reset and zeroes both memories, leaving reset asserted.
  task automatic applyStimulus();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    for (int r = 0; r < NUM_RAYS; r++) setRay(r, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3 * NUM_TRIS; i++) setTriRow(i, 0, 0, 0, 0);
  endtask

  task automatic releaseReset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Ray 0 completion is the first cycle io_hitT leaves zero after reset.
  task automatic waitRay0(input string tag);
    bit done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clock);
      if (io_hitT != 32'h0) done = 1'b1;
    end
    checkOutput({tag, "_ray0_done"}, 64'(done), 64'd1);
  endtask

  task automatic runRay0(input string tag, input logic [31:0] expT,
                         input logic [31:0] expIdTri, input logic [63:0] expFdiv);
    releaseReset();
    waitRay0(tag);
    checkOutput({tag, "_hitT"}, 64'(io_hitT), 64'(expT));
    checkOutput({tag, "_idtri"}, 64'(io_ray_id_triangle), 64'(expIdTri));
    checkOutput({tag, "_fdiv"}, io_counter_fdiv, expFdiv);
  endtask

  initial begin
    bit finished;

    // Reset state
    applyStimulus();
    checkOutput("rst_hitT", 64'(io_hitT), 64'h0);
    checkOutput("rst_idtri", 64'(io_ray_id_triangle), 64'h0);
    checkOutput("rst_finish", 64'(io_rtp_finish), 64'h0);
    checkOutput("rst_fdiv", io_counter_fdiv, 64'h0);

    // Single hit at t=5 on triangle 0
    setStdRay(0);
    setTri(0, 5, 32'h0000_4000, 32'h0000_4000);
    runRay0("hit5", 32'h0005_0000, 32'h0000_0000, 64'd1);

    // Every triangle parallel to the ray: no divisions, miss
    applyStimulus();
    setStdRay(0);
    setTriRow(0, ONE, 32'h0, 32'h0, 32'h0);
    runRay0("dz0", TMAX, 32'h0000_FFFF, 64'd0);

    // Closer hit on a later triangle wins
    applyStimulus();
    setStdRay(0);
    setTri(0, 3, 32'h0000_4000, 32'h0000_4000);
    setTri(1, 2, 32'h0000_4000, 32'h0000_4000);
    runRay0("closer", 32'h0002_0000, 32'h0000_0001, 64'd2);

    // Equal distance keeps the lower triangle index
    applyStimulus();
    setStdRay(0);
    setTri(0, 2, 32'h0000_4000, 32'h0000_4000);
    setTri(1, 2, 32'h0000_4000, 32'h0000_4000);
    runRay0("tie", 32'h0002_0000, 32'h0000_0000, 64'd2);

    // u=-1 and u+v=1.5 both miss
    applyStimulus();
    setStdRay(0);
    setTri(0, 2, 32'hFFFF_0000, 32'h0000_4000);
    setTri(1, 3, 32'h0000_C000, 32'h0000_C000);
    runRay0("uvmiss", TMAX, 32'h0000_FFFF, 64'd2);

    // u=v=0.5 hits; u+v just over 1 misses; negative t skipped after division
    applyStimulus();
    setStdRay(0);
    setTri(0, 4, 32'h0000_8000, 32'h0000_8000);
    setTri(1, 3, 32'h0000_8000, 32'h0000_8001);
    setTri(2, -1, 32'h0000_4000, 32'h0000_4000);
    runRay0("edge", 32'h0004_0000, 32'h0000_0000, 64'd3);

    // Fractional quotient truncated: 1.0 / 3.0 = 0x5555
    applyStimulus();
    setStdRay(0);
    setTriRow(0, 32'h0, 32'h0, 32'h0003_0000, 32'hFFF2_0000);
    setTriRow(1, 32'h0, 32'h0, ONE, 32'h0005_0000);
    setTriRow(2, 32'h0, 32'h0, 32'h0, 32'h0);
    runRay0("frac", 32'h0000_5555, 32'h0000_0000, 64'd1);

    // Full sweep: every triangle divides, t decreases so triangle 31 wins (t=9)
    applyStimulus();
    for (int r = 0; r < NUM_RAYS; r++) setStdRay(r);
    for (int k = 0; k < NUM_TRIS; k++) setTri(k, 40 - k, 32'h0000_4000, 32'h0000_4000);
    releaseReset();
    finished = 1'b0;
    for (int c = 0; c < 20000 && !finished; c++) begin
      @(negedge clock);
      if (io_rtp_finish) finished = 1'b1;
    end
    checkOutput("sweep_done", 64'(finished), 64'd1);
    checkOutput("sweep_fdiv", io_counter_fdiv, 64'd512);
    checkOutput("sweep_idtri", 64'(io_ray_id_triangle), 64'h000F_001F);
    checkOutput("sweep_hitT", 64'(io_hitT), 64'h0009_0000);
    repeat (50) @(negedge clock);
    checkOutput("sweep_finish_hold", 64'(io_rtp_finish), 64'd1);
    checkOutput("sweep_fdiv_hold", io_counter_fdiv, 64'd512);

    // Reset partway through a sweep, memories untouched
    reset = 1'b1;
    @(negedge clock);
    releaseReset();
    repeat (3000) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midrst_hitT", 64'(io_hitT), 64'h0);
    checkOutput("midrst_idtri", 64'(io_ray_id_triangle), 64'h0);
    checkOutput("midrst_finish", 64'(io_rtp_finish), 64'h0);
    checkOutput("midrst_fdiv", io_counter_fdiv, 64'h0);
    runRay0("restart", 32'h0009_0000, 32'h0000_001F, 64'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end
endmodule
